// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg
//   Shared definitions for the GPIO serial configuration loader: pad word
//   width, loader state encoding, field offsets inside a pad word and a
//   small elaboration-time helper.
package gpio_cfg_pkg;

  // Configuration bits carried per pad.
  localparam int CFG_BITS = 13;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LOAD     = 3'd3,
    DONE     = 3'd4
  } loader_state_t;

  // Field offsets inside one pad word.
  localparam int DM_HI       = 12;
  localparam int DM_LO       = 10;
  localparam int VTRIP_SEL   = 9;
  localparam int SLOW_SEL    = 8;
  localparam int ANALOG_POL  = 7;
  localparam int ANALOG_SEL  = 6;
  localparam int ANALOG_EN   = 5;
  localparam int IB_MODE_SEL = 4;
  localparam int INP_DIS     = 3;
  localparam int HOLDOVER    = 2;
  localparam int OEB         = 1;
  localparam int MGMT_ENA    = 0;

  // Larger of two integers, used to size the per-chain word slots.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/gpio_serial_phase.sv
// gpio_serial_phase
//   Half-period timer for the serial clock. Counts CLK_DIV cycles and raises
//   tick during the last cycle of each phase. restart forces the count back
//   to the first cycle of a phase on the next edge.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   restart - begin a new phase on the next edge
//   tick    - high in the final cycle of the current phase
module gpio_serial_phase
  import gpio_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] count_r;

  assign tick = (count_r == LAST);

  // Phase cycle counter; saturates on the last cycle until restarted.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (restart) begin
      count_r <= '0;
    end else if (!tick) begin
      count_r <= count_r + PW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
//   Snapshots all pad configuration words on start and shifts them, MSB
//   first and farthest pad first, onto two parallel serial chains with a
//   divided shift clock, then pulses a load strobe so every pad commits at
//   once. The shorter chain is padded with leading all-zero words so both
//   chains finish on the same bit.
// Ports:
//   wb_clk_i      - clock
//   wb_rst_i      - synchronous active-high reset
//   start         - single-cycle load request (ignored unless idle)
//   cfg_words     - pad p word at [p*CFG_BITS +: CFG_BITS]
//   busy          - transfer in progress
//   done          - one-cycle completion pulse
//   serial_clock  - shift clock to both chains (chains sample on rise)
//   serial_load   - parallel-load strobe to both chains
//   serial_resetn - chain reset, low only while wb_rst_i is high
//   serial_data_1 - chain 1 data (pads AREA1PADS-1 .. 0)
//   serial_data_2 - chain 2 data (pads AREA1PADS .. NUM_PADS-1)
module gpio_serial_loader #(
  parameter int NUM_PADS  = 38,
  parameter int AREA1PADS = 19,
  parameter int CFG_BITS  = gpio_cfg_pkg::CFG_BITS,
  parameter int CLK_DIV   = 4
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         start,
  input  logic [NUM_PADS*CFG_BITS-1:0] cfg_words,
  output logic                         busy,
  output logic                         done,
  output logic                         serial_clock,
  output logic                         serial_load,
  output logic                         serial_resetn,
  output logic                         serial_data_1,
  output logic                         serial_data_2
);
  import gpio_cfg_pkg::*;

  localparam int AREA2PADS = NUM_PADS - AREA1PADS;
  localparam int W         = max_int(AREA1PADS, AREA2PADS);
  localparam int B         = W * CFG_BITS;
  localparam int CNT_W     = $clog2(B + 1);
  localparam int A1_BITS   = AREA1PADS * CFG_BITS;

  loader_state_t    state_r;
  logic [B-1:0]     shift1_r;
  logic [B-1:0]     shift2_r;
  logic [B-1:0]     snap1_s;
  logic [B-1:0]     snap2_s;
  logic [B-1:0]     next1_s;
  logic [B-1:0]     next2_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             phase_tick_s;
  logic             phase_restart_s;

  // Chain 1 image: pad words already lie highest-pad-highest, which is the
  // shift order, so they drop straight in below the zero padding.
  always_comb begin
    snap1_s = '0;
    snap1_s[A1_BITS-1:0] = cfg_words[A1_BITS-1:0];
  end

  // Chain 2 image: pad AREA1PADS must leave first, so pad order is reversed
  // word-wise (last pad lands in the lowest slot), zero padding above.
  always_comb begin
    snap2_s = '0;
    for (int s = 0; s < AREA2PADS; s++) begin
      snap2_s[s*CFG_BITS +: CFG_BITS] = cfg_words[(NUM_PADS-1-s)*CFG_BITS +: CFG_BITS];
    end
  end

  assign next1_s = {shift1_r[B-2:0], 1'b0};
  assign next2_s = {shift2_r[B-2:0], 1'b0};

  // Every phase end in an active state is also a state change, and the
  // counter is held at its first cycle while idle or finishing.
  assign phase_restart_s = (state_r == IDLE) || (state_r == DONE) || phase_tick_s;

  gpio_serial_phase #(
    .CLK_DIV(CLK_DIV)
  ) u_phase (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .restart(phase_restart_s),
    .tick   (phase_tick_s)
  );

  // Loader FSM with registered serial outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r       <= IDLE;
      shift1_r      <= '0;
      shift2_r      <= '0;
      bit_cnt_r     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b0;
      serial_data_1 <= 1'b0;
      serial_data_2 <= 1'b0;
    end else begin
      serial_resetn <= 1'b1;
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift1_r      <= snap1_s;
            shift2_r      <= snap2_s;
            bit_cnt_r     <= CNT_W'(B);
            serial_data_1 <= snap1_s[B-1];
            serial_data_2 <= snap2_s[B-1];
            busy          <= 1'b1;
            state_r       <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_tick_s) begin
            serial_clock <= 1'b1;
            state_r      <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (phase_tick_s) begin
            serial_clock <= 1'b0;
            // Counter reaching zero after this decrement means the last bit was clocked.
            if (bit_cnt_r != CNT_W'(1)) begin
              bit_cnt_r     <= bit_cnt_r - CNT_W'(1);
              shift1_r      <= next1_s;
              shift2_r      <= next2_s;
              serial_data_1 <= next1_s[B-1];
              serial_data_2 <= next2_s[B-1];
              state_r       <= SHIFT_LO;
            end else begin
              bit_cnt_r     <= '0;
              serial_data_1 <= 1'b0;
              serial_data_2 <= 1'b0;
              serial_load   <= 1'b1;
              state_r       <= LOAD;
            end
          end
        end
        LOAD: begin
          if (phase_tick_s) begin
            serial_load <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r       <= IDLE;
          busy          <= 1'b0;
          done          <= 1'b0;
          serial_clock  <= 1'b0;
          serial_load   <= 1'b0;
          serial_data_1 <= 1'b0;
          serial_data_2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader
//   Two loaders share clock, reset and cfg_words: instance 0 uses the default
//   geometry (19/19 pads, CLK_DIV=4, B=247); instance 1 uses an uneven split
//   (10/28 pads, CLK_DIV=1, B=364). Timestamps follow the convention that a
//   start driven in cycle k is sampled at the end of that cycle.
module tb_gpio_serial_loader;

  localparam int NP = 38;
  localparam int CB = 13;
  localparam int NB = NP * CB;

  typedef struct {
    int            inst;
    logic [NB-1:0] cfg;
    bit            flip;
    bit            poke;
    int            exp_bits;
    int            exp_rise;
    int            exp_load;
    int            exp_load_len;
    int            exp_done;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start [2];
  logic [NB-1:0] cfg;
  logic          busy [2];
  logic          dn [2];
  logic          sc [2];
  logic          ld [2];
  logic          rn [2];
  logic          d1 [2];
  logic          d2 [2];
  int            cyc = 0;

  int total = 0;
  int bad   = 0;

  int a1p [2] = '{19, 10};
  int wsl [2] = '{19, 28};

  // Monitor bookkeeping, written only by the monitor process (arm by the task).
  int            arm [2]      = '{0, 0};
  int            arm_seen [2] = '{-1, -1};
  int            rises [2];
  int            first_rise [2];
  int            busy_first [2];
  int            busy_fall [2];
  int            load_first [2];
  int            load_len [2];
  int            done_cyc [2];
  int            done_cnt [2];
  int            viol [2];
  logic [511:0]  m1 [2];
  logic [511:0]  m2 [2];
  logic          sc_p [2];
  logic          d1_p [2];
  logic          d2_p [2];

  logic [NB-1:0] pa;
  logic [NB-1:0] pb;
  vec_t          vt [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpio_serial_loader #(.NUM_PADS(38), .AREA1PADS(19), .CFG_BITS(13), .CLK_DIV(4)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start[0]), .cfg_words(cfg),
    .busy(busy[0]), .done(dn[0]), .serial_clock(sc[0]), .serial_load(ld[0]),
    .serial_resetn(rn[0]), .serial_data_1(d1[0]), .serial_data_2(d2[0]));

  gpio_serial_loader #(.NUM_PADS(38), .AREA1PADS(10), .CFG_BITS(13), .CLK_DIV(1)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start[1]), .cfg_words(cfg),
    .busy(busy[1]), .done(dn[1]), .serial_clock(sc[1]), .serial_load(ld[1]),
    .serial_resetn(rn[1]), .serial_data_1(d1[1]), .serial_data_2(d2[1]));

  // Chain model and event timing capture, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (arm_seen[i] != arm[i]) begin
        arm_seen[i]   = arm[i];
        rises[i]      = 0;
        first_rise[i] = -1;
        busy_first[i] = -1;
        busy_fall[i]  = -1;
        load_first[i] = -1;
        load_len[i]   = 0;
        done_cyc[i]   = -1;
        done_cnt[i]   = 0;
        viol[i]       = 0;
        m1[i]         = '0;
        m2[i]         = '0;
      end else begin
        if (busy[i] === 1'b1 && busy_first[i] < 0) busy_first[i] = cyc;
        if (busy[i] === 1'b0 && busy_first[i] >= 0 && busy_fall[i] < 0) busy_fall[i] = cyc;
        if (sc[i] === 1'b1 && sc_p[i] === 1'b0) begin
          rises[i] = rises[i] + 1;
          if (first_rise[i] < 0) first_rise[i] = cyc;
          m1[i] = {m1[i][510:0], d1[i]};
          m2[i] = {m2[i][510:0], d2[i]};
        end
        if (sc[i] === 1'b1 && sc_p[i] === 1'b1 && (d1[i] !== d1_p[i] || d2[i] !== d2_p[i]))
          viol[i] = viol[i] + 1;
        if (ld[i] === 1'b1) begin
          if (load_first[i] < 0) load_first[i] = cyc;
          load_len[i] = load_len[i] + 1;
          if (sc[i] !== 1'b0 || d1[i] !== 1'b0 || d2[i] !== 1'b0) viol[i] = viol[i] + 1;
        end
        if (dn[i] === 1'b1) begin
          if (done_cyc[i] < 0) done_cyc[i] = cyc;
          done_cnt[i] = done_cnt[i] + 1;
          if (busy[i] !== 1'b0) viol[i] = viol[i] + 1;
        end
      end
      sc_p[i] = sc[i];
      d1_p[i] = d1[i];
      d2_p[i] = d2[i];
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int i;
    int k;
    int lim;
    logic [511:0] e1;
    logic [511:0] e2;
    logic [CB-1:0] w;
    i   = v.inst;
    cfg = v.cfg;
    @(negedge clk);
    arm[i] = arm[i] + 1;
    @(negedge clk);
    start[i] = 1'b1;
    k   = cyc;
    lim = k + v.exp_done + 6;
    while (cyc < lim) begin
      @(negedge clk);
      start[i] = 1'b0;
      if (v.flip && cyc == k + 10) cfg = '1;
      if (v.poke && (cyc == k + 50 || dn[i] === 1'b1)) start[i] = 1'b1;
    end
    start[i] = 1'b0;

    // Expected bit streams: zero padding, then farthest pad first, MSB first.
    e1 = '0;
    e2 = '0;
    for (int z = 0; z < (wsl[i] - a1p[i]) * CB; z++) e1 = {e1[510:0], 1'b0};
    for (int p = a1p[i] - 1; p >= 0; p--) begin
      w = v.cfg[p*CB +: CB];
      for (int b = CB - 1; b >= 0; b--) e1 = {e1[510:0], w[b]};
    end
    for (int z = 0; z < (wsl[i] - (NP - a1p[i])) * CB; z++) e2 = {e2[510:0], 1'b0};
    for (int p = a1p[i]; p < NP; p++) begin
      w = v.cfg[p*CB +: CB];
      for (int b = CB - 1; b >= 0; b--) e2 = {e2[510:0], w[b]};
    end

    chk("sclk_rises", rises[i], v.exp_bits);
    chk("busy_rise_at", busy_first[i] - k, 1);
    chk("first_sclk_rise_at", first_rise[i] - k, v.exp_rise);
    chk("load_at", load_first[i] - k, v.exp_load);
    chk("load_len", load_len[i], v.exp_load_len);
    chk("done_at", done_cyc[i] - k, v.exp_done);
    chk("done_pulses", done_cnt[i], 1);
    chk("busy_fall_at", busy_fall[i] - k, v.exp_done);
    chk("protocol_violations", viol[i], 0);
    chk_vec("chain1_contents", m1[i], e1);
    chk_vec("chain2_contents", m2[i], e2);
    chk("idle_after_done", busy[i], 0);
  endtask

  initial begin
    int k;
    start[0] = 1'b1;
    start[1] = 1'b1;
    for (int p = 0; p < NP; p++) begin
      pa[p*CB +: CB] = CB'(p) ^ 13'h1A5;
      pb[p*CB +: CB] = CB'(p * 179) ^ 13'h1555;
    end
    cfg = pa;

    vt[0] = '{inst: 0, cfg: pa, flip: 1'b0, poke: 1'b0, exp_bits: 247, exp_rise: 5, exp_load: 1977, exp_load_len: 4, exp_done: 1981};
    vt[1] = '{inst: 1, cfg: pa, flip: 1'b0, poke: 1'b0, exp_bits: 364, exp_rise: 2, exp_load: 729,  exp_load_len: 1, exp_done: 730};
    vt[2] = '{inst: 0, cfg: pb, flip: 1'b0, poke: 1'b1, exp_bits: 247, exp_rise: 5, exp_load: 1977, exp_load_len: 4, exp_done: 1981};
    vt[3] = '{inst: 0, cfg: pa, flip: 1'b1, poke: 1'b0, exp_bits: 247, exp_rise: 5, exp_load: 1977, exp_load_len: 4, exp_done: 1981};
    vt[4] = '{inst: 1, cfg: pb, flip: 1'b1, poke: 1'b1, exp_bits: 364, exp_rise: 2, exp_load: 729,  exp_load_len: 1, exp_done: 730};

    // Reset held three cycles with start high on both instances.
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("reset_outputs", {busy[i], dn[i], sc[i], ld[i], d1[i], d2[i]}, 0);
        chk("reset_resetn_low", rn[i], 0);
      end
    end
    rst      = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("resetn_after_release", rn[i], 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("no_start_from_reset", {busy[i], sc[i], ld[i]}, 0);

    for (int n = 0; n < 5; n++) run_vec(vt[n]);

    // Reset in the middle of a transfer.
    cfg = pa;
    @(negedge clk);
    arm[0] = arm[0] + 1;
    @(negedge clk);
    start[0] = 1'b1;
    k = cyc;
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc < k + 500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_sclk", sc[0], 0);
    chk("midrst_resetn", rn[0], 0);
    chk("midrst_load", ld[0], 0);
    chk("midrst_data", {d1[0], d2[0]}, 0);
    rst = 1'b0;
    repeat (2200) @(negedge clk);
    chk("midrst_no_load", load_len[0], 0);
    chk("midrst_no_done", done_cnt[0], 0);
    chk("midrst_bits_before", rises[0], 62);
    run_vec(vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
